multicycle_controller: RTL and testbench

- Parametrised, multi-cycle sequencing controller for the datapath (PC, register file, ALU, data memory).
- Latches one instruction per step into an internal IR and decodes it to registered field/mux outputs.
- Sequences write enables over DECODE/EXEC/MEM states with a ready handshake to data memory.
- Adds single-step/run modes, memory timeout, busy and sticky fault flags.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/multicycle_controller_if.sv | 48 ++++
 rtl/rise_edge_detect.sv | 27 ++
 rtl/multicycle_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ctrl_pkg : shared opcodes, FSM states and default widths for the controller
// Rev 1.0
// ============================================================================
package ctrl_pkg;

    localparam int OPC_W_DEF       = 3;
    localparam int RA_W_DEF        = 3;
    localparam int DA_W_DEF        = 4;
    localparam int INSTR_W_DEF     = OPC_W_DEF + 3 * RA_W_DEF;
    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_SUB   = 3'b010,
        OP_ADDI  = 3'b101,
        OP_JEQ   = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        MEM    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// multicycle_controller_if : instruction, handshake and datapath-control bundle
// Rev 1.0
// ============================================================================
interface multicycle_controller_if #(
    parameter int RA_W    = ctrl_pkg::RA_W_DEF,
    parameter int DA_W    = ctrl_pkg::DA_W_DEF,
    parameter int INSTR_W = ctrl_pkg::INSTR_W_DEF
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               step;
    logic               run;
    logic               is_external;
    logic               eq;
    logic               mem_ready;

    logic               pc_ld;
    logic               pc_sel;
    logic               reg_wr_sel;
    logic               m_we;
    logic               m_re;
    logic               alu_src_sel;
    logic               alu_op;
    logic               rf_we;
    logic [RA_W-1:0]    ra1;
    logic [RA_W-1:0]    ra2;
    logic [RA_W-1:0]    wa;
    logic [DA_W-1:0]    da;
    logic [RA_W-1:0]    constant;
    logic               busy;
    logic               illegal;
    logic               mem_fault;

    modport master (
        input  instr, instr_valid, step, run, is_external, eq, mem_ready,
        output pc_ld, pc_sel, reg_wr_sel, m_we, m_re, alu_src_sel, alu_op, rf_we,
               ra1, ra2, wa, da, constant, busy, illegal, mem_fault
    );

    modport slave (
        output instr, instr_valid, step, run, is_external, eq, mem_ready,
        input  pc_ld, pc_sel, reg_wr_sel, m_we, m_re, alu_src_sel, alu_op, rf_we,
               ra1, ra2, wa, da, constant, busy, illegal, mem_fault
    );
endinterface
`default_nettype wire

// File: rtl/rise_edge_detect.sv
`default_nettype none
// ============================================================================
// rise_edge_detect : one-cycle pulse on the rising edge of a level input
// Rev 1.0
// ============================================================================
module rise_edge_detect (
    input  wire  clk,
    input  wire  reset_n,
    input  wire  i_level,
    output logic o_pulse
);
    logic level_q;
    logic level_d;

    always_comb level_d = i_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_pulse = i_level & ~level_q;
endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : IDLE/DECODE/EXEC/MEM sequencer for the PC/RF/ALU/memory datapath
// Rev 1.0
// ============================================================================
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPC_W       = OPC_W_DEF,
    parameter int RA_W        = RA_W_DEF,
    parameter int DA_W        = DA_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  wire                     clk,
    input  wire                     reset_n,
    multicycle_controller_if.master bus
);
    localparam int CONST_W = RA_W;
    localparam int CNT_W   = $clog2(MEM_TIMEOUT + 1);

    if (INSTR_W != OPC_W + 3 * RA_W) begin : g_bad_instr_w
        $error("INSTR_W must equal OPC_W + 3*RA_W");
    end
    if (DA_W + RA_W > 3 * RA_W) begin : g_bad_da_w
        $error("DA_W + RA_W must not exceed 3*RA_W");
    end
    if (OPC_W != OPC_W_DEF) begin : g_bad_opc_w
        $error("OPC_W must match the opcode encoding width");
    end

    state_t              state_q,       state_d;
    logic [INSTR_W-1:0]  ir_q,          ir_d;
    logic [RA_W-1:0]     ra1_q,         ra1_d;
    logic [RA_W-1:0]     ra2_q,         ra2_d;
    logic [RA_W-1:0]     wa_q,          wa_d;
    logic [DA_W-1:0]     da_q,          da_d;
    logic [CONST_W-1:0]  constant_q,    constant_d;
    logic                alu_src_sel_q, alu_src_sel_d;
    logic                alu_op_q,      alu_op_d;
    logic                reg_wr_sel_q,  reg_wr_sel_d;
    logic                illegal_q,     illegal_d;
    logic                mem_fault_q,   mem_fault_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;

    logic                step_pulse;
    logic                go;
    logic [OPC_W-1:0]    opc;
    logic [RA_W-1:0]     f_lo, f_mid, f_top, f_lw;
    logic [DA_W-1:0]     f_da;
    logic                pc_ld, pc_sel, rf_we, m_re, m_we;

    rise_edge_detect u_step_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_level (bus.step),
        .o_pulse (step_pulse)
    );

    assign go    = bus.instr_valid & (bus.run | step_pulse);
    assign opc   = ir_q[INSTR_W-1 -: OPC_W];
    assign f_lo  = ir_q[RA_W-1:0];
    assign f_mid = ir_q[2*RA_W-1:RA_W];
    assign f_top = ir_q[3*RA_W-1:2*RA_W];
    assign f_lw  = ir_q[DA_W+RA_W-1:DA_W];
    assign f_da  = ir_q[DA_W-1:0];

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        ra1_d         = ra1_q;
        ra2_d         = ra2_q;
        wa_d          = wa_q;
        da_d          = da_q;
        constant_d    = constant_q;
        alu_src_sel_d = alu_src_sel_q;
        alu_op_d      = alu_op_q;
        reg_wr_sel_d  = reg_wr_sel_q;
        illegal_d     = illegal_q;
        mem_fault_d   = mem_fault_q;
        cnt_d         = cnt_q;
        pc_ld         = 1'b0;
        pc_sel        = 1'b0;
        rf_we         = 1'b0;
        m_re          = 1'b0;
        m_we          = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Fields not used by the opcode are forced to zero.
                ra1_d         = '0;
                ra2_d         = '0;
                wa_d          = '0;
                da_d          = '0;
                constant_d    = '0;
                alu_src_sel_d = 1'b0;
                alu_op_d      = 1'b0;
                reg_wr_sel_d  = 1'b0;
                case (opc)
                    OP_LOAD: begin
                        wa_d = f_lw;
                        da_d = f_da;
                    end
                    OP_STORE: begin
                        ra2_d = f_lw;
                        da_d  = f_da;
                    end
                    OP_SUB: begin
                        ra1_d         = f_lo;
                        ra2_d         = f_mid;
                        wa_d          = f_top;
                        alu_src_sel_d = 1'b1;
                        reg_wr_sel_d  = 1'b1;
                    end
                    OP_ADDI: begin
                        ra1_d        = f_mid;
                        constant_d   = f_lo;
                        wa_d         = f_top;
                        alu_op_d     = 1'b1;
                        reg_wr_sel_d = 1'b1;
                    end
                    OP_JEQ: begin
                        ra1_d         = f_lo;
                        ra2_d         = f_mid;
                        constant_d    = f_top;
                        alu_src_sel_d = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
                state_d = EXEC;
            end
            EXEC: begin
                case (opc)
                    OP_LOAD: begin
                        m_re    = 1'b1;
                        state_d = MEM;
                    end
                    OP_STORE: begin
                        m_we    = 1'b1;
                        state_d = MEM;
                    end
                    OP_SUB, OP_ADDI: begin
                        rf_we   = 1'b1;
                        pc_ld   = ~bus.is_external;
                        state_d = IDLE;
                    end
                    OP_JEQ: begin
                        pc_sel  = bus.eq;
                        pc_ld   = ~bus.is_external;
                        state_d = IDLE;
                    end
                    default: begin
                        pc_ld   = ~bus.is_external;
                        state_d = IDLE;
                    end
                endcase
            end
            MEM: begin
                m_re = (opc == OP_LOAD);
                m_we = (opc == OP_STORE);
                if (bus.mem_ready) begin
                    rf_we   = (opc == OP_LOAD);
                    pc_ld   = ~bus.is_external;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    // Last permitted wait cycle: give up without committing or advancing the PC.
                    mem_fault_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ir_q          <= '0;
            ra1_q         <= '0;
            ra2_q         <= '0;
            wa_q          <= '0;
            da_q          <= '0;
            constant_q    <= '0;
            alu_src_sel_q <= 1'b0;
            alu_op_q      <= 1'b0;
            reg_wr_sel_q  <= 1'b0;
            illegal_q     <= 1'b0;
            mem_fault_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            ra1_q         <= ra1_d;
            ra2_q         <= ra2_d;
            wa_q          <= wa_d;
            da_q          <= da_d;
            constant_q    <= constant_d;
            alu_src_sel_q <= alu_src_sel_d;
            alu_op_q      <= alu_op_d;
            reg_wr_sel_q  <= reg_wr_sel_d;
            illegal_q     <= illegal_d;
            mem_fault_q   <= mem_fault_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.pc_ld       = pc_ld;
    assign bus.pc_sel      = pc_sel;
    assign bus.rf_we       = rf_we;
    assign bus.m_re        = m_re;
    assign bus.m_we        = m_we;
    assign bus.ra1         = ra1_q;
    assign bus.ra2         = ra2_q;
    assign bus.wa          = wa_q;
    assign bus.da          = da_q;
    assign bus.constant    = constant_q;
    assign bus.alu_src_sel = alu_src_sel_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.reg_wr_sel  = reg_wr_sel_q;
    assign bus.illegal     = illegal_q;
    assign bus.mem_fault   = mem_fault_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : randomized transactions against a per-instruction reference model
// Rev 1.0
// ============================================================================
module tb_multicycle_controller;
    localparam int RA_W        = 3;
    localparam int DA_W        = 4;
    localparam int INSTR_W     = 12;
    localparam int MEM_TIMEOUT = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    multicycle_controller_if #(.RA_W(RA_W), .DA_W(DA_W), .INSTR_W(INSTR_W)) bus ();

    multicycle_controller #(
        .OPC_W       (3),
        .RA_W        (RA_W),
        .DA_W        (DA_W),
        .INSTR_W     (INSTR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          exp_illegal;
    bit          exp_mem_fault;
    logic [18:0] exp_fields;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Field outputs an instruction should produce, straight from the opcode table.
    function automatic logic [18:0] ref_fields(input int unsigned ins);
        int unsigned opc = ins / 512;
        int unsigned lo  = ins % 8;
        int unsigned mid = (ins / 8) % 8;
        int unsigned top = (ins / 64) % 8;
        int unsigned dfl = ins % 16;
        int unsigned lw  = (ins / 16) % 8;
        int unsigned r1 = 0, r2 = 0, w = 0, d = 0, c = 0, src = 0, aop = 0, wsel = 0;
        case (opc)
            0: begin w = lw; d = dfl; end
            1: begin r2 = lw; d = dfl; end
            2: begin r1 = lo; r2 = mid; w = top; src = 1; wsel = 1; end
            5: begin r1 = mid; c = lo; w = top; aop = 1; wsel = 1; end
            7: begin r1 = lo; r2 = mid; c = top; src = 1; end
            default: ;
        endcase
        return {r1[2:0], r2[2:0], w[2:0], d[3:0], c[2:0], src[0], aop[0], wsel[0]};
    endfunction

    function automatic bit is_legal(input int unsigned opc);
        return (opc == 0) || (opc == 1) || (opc == 2) || (opc == 5) || (opc == 7);
    endfunction

    function automatic logic [5:0] obs_en();
        return {bus.busy, bus.pc_ld, bus.pc_sel, bus.rf_we, bus.m_re, bus.m_we};
    endfunction

    function automatic logic [18:0] obs_fields();
        return {bus.ra1, bus.ra2, bus.wa, bus.da, bus.constant,
                bus.alu_src_sel, bus.alu_op, bus.reg_wr_sel};
    endfunction

    // One instruction from its go cycle (k=0) to the cycle it finishes (k=last).
    // lat = MEM cycles before mem_ready; eq_sel/ext_sel < 0 means random each cycle;
    // abort_k >= 0 pulls reset_n low in that cycle.
    task automatic run_instr(input logic [11:0] ins, input bit use_run, input bit hold_step,
                             input int lat, input int abort_k, input int eq_sel, input int ext_sel);
        int unsigned opc;
        bit          is_mem;
        bit          timeout;
        int          last;
        logic [5:0]  exp_en;
        bit          eqv;
        bit          extv;
        opc     = {29'd0, ins[11:9]};
        is_mem  = (opc <= 1);
        timeout = is_mem && (lat >= MEM_TIMEOUT);
        if (!is_mem)      last = 2;
        else if (timeout) last = 2 + MEM_TIMEOUT;
        else              last = 3 + lat;

        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            eqv  = (eq_sel  < 0) ? 1'($urandom % 2) : eq_sel[0];
            extv = (ext_sel < 0) ? 1'($urandom % 2) : ext_sel[0];
            bus.eq          = eqv;
            bus.is_external = extv;
            bus.run         = use_run;
            if (k == 0) begin
                bus.instr       = ins;
                bus.instr_valid = 1'b1;
                bus.step        = !use_run;
                bus.mem_ready   = 1'($urandom % 2);
            end else begin
                bus.instr       = 12'($urandom);
                bus.instr_valid = 1'($urandom % 2);
                bus.step        = hold_step && !use_run;
                bus.mem_ready   = (k >= 3) ? (k - 3 == lat) : 1'($urandom % 2);
            end

            if (k == abort_k) begin
                reset_n = 1'b0;
                #1;
                check_val("abort_en", 32'(obs_en()), 32'd0);
                check_val("abort_fields", 32'(obs_fields()), 32'd0);
                check_val("abort_flags", {30'd0, bus.illegal, bus.mem_fault}, 32'd0);
                exp_fields    = '0;
                exp_illegal   = 1'b0;
                exp_mem_fault = 1'b0;
                @(negedge clk);
                bus.step = 1'b0;
                reset_n  = 1'b1;
                return;
            end
            #1;

            if (k == 2) begin
                exp_fields = ref_fields({20'd0, ins});
                if (!is_legal(opc)) exp_illegal = 1'b1;
            end

            exp_en = '0;
            if (k >= 1) exp_en[5] = 1'b1;
            if (k == 2) begin
                case (opc)
                    0:       exp_en[1] = 1'b1;
                    1:       exp_en[0] = 1'b1;
                    2, 5:    begin exp_en[2] = 1'b1; exp_en[4] = !extv; end
                    7:       begin exp_en[3] = eqv;  exp_en[4] = !extv; end
                    default: exp_en[4] = !extv;
                endcase
            end
            if (k >= 3) begin
                exp_en[1] = (opc == 0);
                exp_en[0] = (opc == 1);
                if (k - 3 == lat) begin
                    exp_en[2] = (opc == 0);
                    exp_en[4] = !extv;
                end
            end
            check_val($sformatf("en_%03h_k%0d", ins, k), 32'(obs_en()), 32'(exp_en));
            if (k <= 2 || k == last)
                check_val($sformatf("fields_%03h_k%0d", ins, k), 32'(obs_fields()), 32'(exp_fields));
            if (k == 0 || k == 2)
                check_val($sformatf("flags_%03h_k%0d", ins, k),
                          {30'd0, bus.illegal, bus.mem_fault}, {30'd0, exp_illegal, exp_mem_fault});
        end
        if (timeout) exp_mem_fault = 1'b1;
    endtask

    // Cycles in which no instruction may start; hold=1 keeps step high with valid asserted.
    task automatic idle_cycles(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.instr       = 12'($urandom);
            bus.eq          = 1'($urandom % 2);
            bus.is_external = 1'($urandom % 2);
            bus.mem_ready   = 1'($urandom % 2);
            if (hold) begin
                bus.step        = 1'b1;
                bus.instr_valid = 1'b1;
                bus.run         = 1'b0;
            end else begin
                bus.instr_valid = 1'b0;
                bus.run         = 1'($urandom % 2);
                bus.step        = (i == n - 1) ? 1'b0 : 1'($urandom % 2);
            end
            #1;
            check_val("idle_en", 32'(obs_en()), 32'd0);
            check_val("idle_fields", 32'(obs_fields()), 32'(exp_fields));
        end
    endtask

    initial begin
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.step        = 1'b0;
        bus.run         = 1'b0;
        bus.is_external = 1'b0;
        bus.eq          = 1'b0;
        bus.mem_ready   = 1'b0;
        exp_fields      = '0;
        exp_illegal     = 1'b0;
        exp_mem_fault   = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_val("reset_en", 32'(obs_en()), 32'd0);
        check_val("reset_fields", 32'(obs_fields()), 32'd0);
        check_val("reset_flags", {30'd0, bus.illegal, bus.mem_fault}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_instr(12'h4D1, 1'b0, 1'b0, 0, -1, -1, 0);
        run_instr(12'hA8D, 1'b0, 1'b1, 0, -1, -1, 0);
        idle_cycles(8, 1'b1);
        idle_cycles(2, 1'b0);
        run_instr(12'h035, 1'b0, 1'b0, 3, -1, -1, 0);
        run_instr(12'h22A, 1'b0, 1'b0, 100, -1, -1, 0);
        run_instr(12'hE11, 1'b0, 1'b0, 0, -1, 1, 0);
        run_instr(12'hE11, 1'b0, 1'b0, 0, -1, 0, 0);
        run_instr(12'hE11, 1'b0, 1'b0, 0, -1, 1, 1);
        run_instr(12'h2F3, 1'b0, 1'b0, MEM_TIMEOUT - 1, -1, -1, -1);
        run_instr(12'h0A7, 1'b0, 1'b0, MEM_TIMEOUT, -1, -1, -1);
        run_instr(12'h0C2, 1'b0, 1'b0, 0, -1, -1, -1);
        run_instr(12'h65B, 1'b0, 1'b0, 0, -1, -1, -1);
        run_instr(12'h035, 1'b0, 1'b0, 100, 5, -1, -1);
        for (int i = 0; i < 5; i++)
            run_instr(12'($urandom), 1'b1, 1'b0, $urandom_range(0, 4), -1, -1, -1);

        for (int i = 0; i < 150; i++) begin
            run_instr(12'($urandom), 1'($urandom % 2), 1'b0, $urandom_range(0, 17),
                      ($urandom % 12 == 0) ? $urandom_range(1, 4) : -1, -1, -1);
            if ($urandom % 4 == 0) idle_cycles($urandom_range(1, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
